// File: rtl/interval_timer.sv
// Interval timer: counts a requested number of whole seconds using a
// CLK_HZ-cycle prescaler, with a DONE/LOAD/RUN request handshake toward
// the traffic-light controller. All outputs come straight from registers.
module interval_timer #(
    parameter int CLK_HZ = 10000,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable_general,
    input  logic [CNT_W-1:0] secondsToCount,
    output logic             finished,
    output logic             tick,
    output logic [CNT_W-1:0] seconds_elapsed
);

    localparam int              PS_W    = $clog2(CLK_HZ);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        S_DONE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t           r_state;
    logic [PS_W-1:0]  r_presc;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_elapsed;
    logic             r_finished;
    logic             r_tick;

    state_t           w_state_next;
    logic [PS_W-1:0]  w_presc_next;
    logic [CNT_W-1:0] w_target_next;
    logic [CNT_W-1:0] w_elapsed_next;
    logic             w_finished_next;
    logic             w_tick_next;
    logic             w_sec_done;
    logic [CNT_W-1:0] w_elapsed_inc;

    assign w_sec_done    = (r_presc == PS_LAST);
    assign w_elapsed_inc = r_elapsed + CNT_W'(1);

    // State and datapath registers; reset parks the block in DONE with counters cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_DONE;
            r_presc    <= '0;
            r_target   <= '0;
            r_elapsed  <= '0;
            r_finished <= 1'b1;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_presc    <= w_presc_next;
            r_target   <= w_target_next;
            r_elapsed  <= w_elapsed_next;
            r_finished <= w_finished_next;
            r_tick     <= w_tick_next;
        end
    end

    // Next-state and counter update; a low enable overrides everything and aborts.
    always_comb begin
        w_state_next   = r_state;
        w_presc_next   = r_presc;
        w_target_next  = r_target;
        w_elapsed_next = r_elapsed;
        if (!enable_general) begin
            w_state_next   = S_DONE;
            w_presc_next   = '0;
            w_elapsed_next = '0;
        end else begin
            case (r_state)
                S_DONE: begin
                    // Controller sees finished=1 on this edge and presents the new request during LOAD.
                    w_state_next = S_LOAD;
                end
                S_LOAD: begin
                    w_target_next  = secondsToCount;
                    w_presc_next   = '0;
                    w_elapsed_next = '0;
                    w_state_next   = (secondsToCount != '0) ? S_RUN : S_DONE;
                end
                S_RUN: begin
                    if (w_sec_done) begin
                        w_presc_next   = '0;
                        w_elapsed_next = w_elapsed_inc;
                        // Stop exactly when the count reaches target, so elapsed never passes it.
                        if (w_elapsed_inc == r_target) begin
                            w_state_next = S_DONE;
                        end
                    end else begin
                        w_presc_next = r_presc + PS_W'(1);
                    end
                end
                default: begin
                    w_state_next   = S_DONE;
                    w_presc_next   = '0;
                    w_elapsed_next = '0;
                end
            endcase
        end
    end

    // Output decode of the upcoming state, so outputs are registered alongside it.
    always_comb begin
        w_finished_next = (w_state_next == S_DONE);
        // Tick is high during the RUN cycle whose prescaler value completes a second.
        w_tick_next     = (w_state_next == S_RUN) && (w_presc_next == PS_LAST);
    end

    assign finished        = r_finished;
    assign tick            = r_tick;
    assign seconds_elapsed = r_elapsed;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with CLK_HZ=4 (one second = 4 cycles).
module tb_interval_timer;

    localparam int CLK_HZ = 4;
    localparam int CNT_W  = 16;
    localparam int BOUND  = 400;

    logic             clk;
    logic             reset;
    logic             enable_general;
    logic [CNT_W-1:0] secondsToCount;
    logic             finished;
    logic             tick;
    logic [CNT_W-1:0] seconds_elapsed;

    int checks;
    int errors;

    // Results of the most recent measured interval
    int m_low;
    int m_elapsed;
    int m_tick_end;
    int m_tpos[$];

    interval_timer #(
        .CLK_HZ(CLK_HZ),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable_general (enable_general),
        .secondsToCount (secondsToCount),
        .finished       (finished),
        .tick           (tick),
        .seconds_elapsed(seconds_elapsed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts in DONE with enable high; presents request n, then counts low cycles
    // (LOAD is low cycle 1, RUN cycle k is low cycle k+1) until finished rises.
    task automatic measure(input int n, input int chg_at, input int chg_val);
        m_low = 0;
        m_tpos.delete();
        secondsToCount = CNT_W'(n);
        step();
        while (finished === 1'b0 && m_low < BOUND) begin
            m_low++;
            if (tick === 1'b1) m_tpos.push_back(m_low - 1);
            if (m_low == chg_at) secondsToCount = CNT_W'(chg_val);
            step();
        end
        m_elapsed  = int'(seconds_elapsed);
        m_tick_end = int'(tick);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        enable_general = 1'b1;
        secondsToCount = 16'd3;
        #1 reset = 1'b1;
        #1;
        checks++;
        if (finished !== 1'b1 || tick !== 1'b0 || seconds_elapsed !== 16'd0) begin
            errors++;
            $display("FAIL reset_async: finished=%b tick=%b elapsed=%0d required 1 0 0",
                     finished, tick, seconds_elapsed);
        end
        step();
        step();
        checks++;
        if (finished !== 1'b1 || tick !== 1'b0 || seconds_elapsed !== 16'd0) begin
            errors++;
            $display("FAIL reset_held: finished=%b tick=%b elapsed=%0d required 1 0 0",
                     finished, tick, seconds_elapsed);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_interval();
        measure(3, -1, 0);
        checks++;
        if (m_low !== 13) begin
            errors++;
            $display("FAIL basic_low: got %0d cycles required 13", m_low);
        end
        checks++;
        if (m_tpos.size() !== 3) begin
            errors++;
            $display("FAIL basic_tick_count: got %0d required 3", m_tpos.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (m_tpos[k] !== 4 * (k + 1)) begin
                    errors++;
                    $display("FAIL basic_tick_pos%0d: got RUN cycle %0d required %0d",
                             k, m_tpos[k], 4 * (k + 1));
                end
            end
        end
        checks++;
        if (m_elapsed !== 3 || m_tick_end !== 0) begin
            errors++;
            $display("FAIL basic_end: elapsed=%0d tick=%0d required 3 0", m_elapsed, m_tick_end);
        end
    endtask

    task automatic test_zero_request();
        measure(0, -1, 0);
        checks++;
        if (m_low !== 1) begin
            errors++;
            $display("FAIL zero_low: got %0d cycles required 1", m_low);
        end
        checks++;
        if (m_tpos.size() !== 0 || m_elapsed !== 0) begin
            errors++;
            $display("FAIL zero_end: ticks=%0d elapsed=%0d required 0 0", m_tpos.size(), m_elapsed);
        end
    endtask

    task automatic test_back_to_back();
        measure(2, -1, 0);
        checks++;
        if (m_low !== 9 || m_elapsed !== 2) begin
            errors++;
            $display("FAIL b2b_first: low=%0d elapsed=%0d required 9 2", m_low, m_elapsed);
        end
        // Exactly one high cycle: we are in it now, and the next edge must drop finished.
        checks++;
        if (finished !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: finished=%b required 1", finished);
        end
        measure(1, -1, 0);
        checks++;
        if (m_low !== 5 || m_elapsed !== 1) begin
            errors++;
            $display("FAIL b2b_second: low=%0d elapsed=%0d required 5 1", m_low, m_elapsed);
        end
        checks++;
        if (m_tpos.size() !== 1 || m_tpos[0] !== 4) begin
            errors++;
            $display("FAIL b2b_second_tick: count=%0d required 1 at RUN cycle 4", m_tpos.size());
        end
    endtask

    task automatic test_ignore_change();
        // Request 5, change to 1 during RUN cycle 3
        measure(5, 4, 1);
        checks++;
        if (m_low !== 21 || m_elapsed !== 5) begin
            errors++;
            $display("FAIL ignore_change: low=%0d elapsed=%0d required 21 5", m_low, m_elapsed);
        end
    endtask

    task automatic test_enable_drop();
        secondsToCount = 16'd3;
        step();
        checks++;
        if (finished !== 1'b0) begin
            errors++;
            $display("FAIL drop_load: finished=%b required 0", finished);
        end
        repeat (6) step();
        checks++;
        if (finished !== 1'b0 || seconds_elapsed !== 16'd1) begin
            errors++;
            $display("FAIL drop_run6: finished=%b elapsed=%0d required 0 1", finished, seconds_elapsed);
        end
        enable_general = 1'b0;
        step();
        checks++;
        if (finished !== 1'b1 || seconds_elapsed !== 16'd0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL drop_abort: finished=%b elapsed=%0d tick=%b required 1 0 0",
                     finished, seconds_elapsed, tick);
        end
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (finished !== 1'b1 || tick !== 1'b0 || seconds_elapsed !== 16'd0) begin
                errors++;
                $display("FAIL drop_hold%0d: finished=%b tick=%b elapsed=%0d required 1 0 0",
                         c, finished, tick, seconds_elapsed);
            end
        end
        enable_general = 1'b1;
        measure(1, -1, 0);
        checks++;
        if (m_low !== 5 || m_elapsed !== 1) begin
            errors++;
            $display("FAIL drop_restart: low=%0d elapsed=%0d required 5 1", m_low, m_elapsed);
        end
    endtask

    task automatic test_async_reset();
        secondsToCount = 16'd5;
        step();
        repeat (6) step();
        checks++;
        if (finished !== 1'b0) begin
            errors++;
            $display("FAIL areset_pre: finished=%b required 0", finished);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (finished !== 1'b1 || seconds_elapsed !== 16'd0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: finished=%b elapsed=%0d tick=%b required 1 0 0",
                     finished, seconds_elapsed, tick);
        end
        #1 reset = 1'b0;
        measure(2, -1, 0);
        checks++;
        if (m_low !== 9 || m_elapsed !== 2) begin
            errors++;
            $display("FAIL areset_next: low=%0d elapsed=%0d required 9 2", m_low, m_elapsed);
        end
        checks++;
        if (m_tpos.size() !== 2 || m_tpos[0] !== 4 || m_tpos[1] !== 8) begin
            errors++;
            $display("FAIL areset_ticks: count=%0d required 2 at RUN cycles 4 and 8", m_tpos.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_interval();
        test_zero_request();
        test_back_to_back();
        test_ignore_change();
        test_enable_drop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
INTERVAL_TIMER -- requirements
Module: interval_timer

Interface
REQ-001 Parameter CLK_HZ, default 10000, clock cycles per second (10 kHz system clock); legal range 2..65535.
REQ-002 Parameter CNT_W, default 16, width of the seconds request, target and elapsed counters.
REQ-003 Clocking: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  system clock, 10 kHz nominal; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable_general  input  1  global enable; low aborts and holds the block idle.
REQ-007 secondsToCount  input  CNT_W  requested interval in seconds, driven by the traffic-light controller.
REQ-008 finished  output  1  high means the interval has expired and the block is ready for a new request.
REQ-009 tick  output  1  one-cycle pulse at each completed second while running.
REQ-010 seconds_elapsed  output  CNT_W  whole seconds completed in the current interval.

Function
REQ-011 The block SHALL implement three states: DONE (finished=1), LOAD (finished=0) and RUN (finished=0).
REQ-012 DONE with enable_general=1 SHALL go to LOAD on the next edge; this is the request handshake, because the controller samples finished=1 on that same edge and drives the new secondsToCount.
REQ-013 LOAD SHALL latch secondsToCount into a target register and clear the prescaler and seconds_elapsed.
REQ-014 LOAD SHALL go to RUN if the latched value is nonzero, and to DONE if it is zero (finished low for exactly 1 cycle).
REQ-015 RUN SHALL increment the prescaler every cycle; at prescaler==CLK_HZ-1 it SHALL wrap the prescaler to 0, increment seconds_elapsed and pulse tick for that cycle.
REQ-016 RUN SHALL go to DONE on the edge where seconds_elapsed reaches target: N*CLK_HZ RUN cycles after LOAD, so finished is low for exactly N*CLK_HZ+1 cycles for a request of N.
REQ-017 Changes to secondsToCount outside LOAD SHALL be ignored; the target stays fixed for the whole interval.
REQ-018 In DONE, seconds_elapsed SHALL hold its final value and tick SHALL stay 0.
REQ-019 enable_general=0 in any state SHALL force DONE on the next edge, clear the prescaler and seconds_elapsed and keep tick=0; the block SHALL remain in DONE, not LOAD, while enable is low.
REQ-020 Re-asserting enable_general SHALL start a new handshake from DONE (REQ-012); no interval resumes.
REQ-021 Counter arithmetic SHALL be unsigned CNT_W bits.
REQ-022 seconds_elapsed SHALL never exceed target, so no wrap occurs for targets up to 2^CNT_W-1.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-024 reset=1 SHALL immediately force state=DONE, finished=1, tick=0, seconds_elapsed=0, prescaler=0 and target=0, independent of clk.
REQ-025 Reset asserted mid-RUN SHALL abandon the interval; after release the first edge with enable_general=1 enters LOAD.

Verification (CLK_HZ=4)
REQ-026 Reset release with enable=1 and secondsToCount=3: edge 1 LOAD (finished=0); finished SHALL be low for 13 cycles, with tick at RUN cycles 4, 8 and 12; seconds_elapsed SHALL read 3 when finished rises.
REQ-027 Request 0: finished SHALL be low for exactly 1 cycle, with no tick and seconds_elapsed=0.
REQ-028 Back-to-back requests 2 then 1: finished SHALL be high 1 cycle between intervals, with low periods of 9 then 5 cycles.
REQ-029 Change secondsToCount from 5 to 1 mid-RUN: the interval SHALL still last 5 seconds (21 low cycles).
REQ-030 enable_general dropped at RUN cycle 6 of a 3-second request: the next edge SHALL give finished=1 and seconds_elapsed=0; with enable held low 10 cycles, finished SHALL stay 1 and no LOAD SHALL occur.
REQ-031 Reset pulsed asynchronously between edges mid-RUN: finished SHALL go to 1 without a clock edge; after release, the next request (secondsToCount=2) SHALL time 9 low cycles.
